// File: rtl/resample_sched.sv
// Polyphase resampler scheduler.
//
// Sequences a tap-serial FIR datapath that produces one output per scheduling
// step. Each step advances a signed phase accumulator by step_in; the sign of
// any overflow decides how many upstream samples the next output consumes:
// positive overflow fetches 2 (skip), negative overflow fetches 0 (duplicate),
// otherwise exactly 1. After fetching, TAP_COUNT MAC cycles are issued and
// the result is offered downstream with a valid/ready handshake.
//
// Ports:
//   clk, rst_n       single clock, synchronous active-low reset
//   en               run enable; an operation in progress always completes
//   step_in          signed phase step, sampled at each scheduling step
//   in_valid/ready   upstream sample handshake (ready only while fetching)
//   shift_en         load the accepted sample into the tap delay line
//   tap_idx          tap/coefficient select during MAC
//   mac_en/clr/last  accumulate, clear-before-add (first tap), final tap
//   out_valid/ready  downstream result handshake
//   phase            current accumulator value
//   skip_cnt/dup_cnt saturating counts of 2-input and 0-input outputs
//   busy             high in any state other than idle
module resample_sched #(
  parameter int unsigned TAP_COUNT = 9,
  parameter int unsigned PHASE_W   = 32,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IdxW     = (TAP_COUNT > 1) ? $clog2(TAP_COUNT) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [PHASE_W-1:0] step_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               shift_en,
  output logic [IdxW-1:0]    tap_idx,
  output logic               mac_en,
  output logic               mac_clr,
  output logic               mac_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   skip_cnt,
  output logic [CNT_W-1:0]   dup_cnt,
  output logic               busy
);

  localparam logic [IdxW-1:0] LastTap = IdxW'(TAP_COUNT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StMac,
    StOut
  } state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         rem_q, rem_d;
  logic [IdxW-1:0]    tap_q, tap_d;
  logic [CNT_W-1:0]   skip_q, skip_d;
  logic [CNT_W-1:0]   dup_q, dup_d;

  logic [PHASE_W-1:0] sum;
  logic               pos_ovf;
  logic               neg_ovf;
  logic               sched_go;

  // Wrapped sum; signed overflow detected from operand and result sign bits.
  assign sum     = phase_q + step_in;
  assign pos_ovf = ~phase_q[PHASE_W-1] & ~step_in[PHASE_W-1] &  sum[PHASE_W-1];
  assign neg_ovf =  phase_q[PHASE_W-1] &  step_in[PHASE_W-1] & ~sum[PHASE_W-1];

  // A new output is scheduled from idle, or back-to-back on the output handshake.
  assign sched_go = en & ((state_q == StIdle) | ((state_q == StOut) & out_ready));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    tap_d   = tap_q;
    skip_d  = skip_q;
    dup_d   = dup_q;

    unique case (state_q)
      StIdle: ;
      StFetch: begin
        if (in_valid) begin
          rem_d = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            state_d = StMac;
          end
        end
      end
      StMac: begin
        if (tap_q == LastTap) begin
          tap_d   = '0;
          state_d = StOut;
        end else begin
          tap_d = tap_q + IdxW'(1);
        end
      end
      StOut: begin
        if (out_ready && !en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (sched_go) begin
      phase_d = sum;
      if (pos_ovf) begin
        rem_d   = 2'd2;
        state_d = StFetch;
        if (skip_q != '1) begin
          skip_d = skip_q + CNT_W'(1);
        end
      end else if (neg_ovf) begin
        // Nothing to fetch: reuse the current delay line contents.
        rem_d   = 2'd0;
        state_d = StMac;
        if (dup_q != '1) begin
          dup_d = dup_q + CNT_W'(1);
        end
      end else begin
        rem_d   = 2'd1;
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      rem_q   <= '0;
      tap_q   <= '0;
      skip_q  <= '0;
      dup_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      tap_q   <= tap_d;
      skip_q  <= skip_d;
      dup_q   <= dup_d;
    end
  end

  assign in_ready  = (state_q == StFetch) && (rem_q != 2'd0);
  assign shift_en  = in_ready && in_valid;
  assign mac_en    = (state_q == StMac);
  assign mac_clr   = mac_en && (tap_q == '0);
  assign mac_last  = mac_en && (tap_q == LastTap);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign tap_idx   = tap_q;
  assign phase     = phase_q;
  assign skip_cnt  = skip_q;
  assign dup_cnt   = dup_q;

endmodule

// File: tb/tb_resample_sched.sv
module tb_resample_sched;

  localparam int TAPS = 9;
  localparam longint PMAX = 64'sd2147483647;
  localparam longint PMIN = -64'sd2147483648;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] step_in;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready, shift_en, mac_en, mac_clr, mac_last, out_valid, busy;
  logic [3:0]  tap_idx;
  logic [31:0] phase;
  logic [15:0] skip_cnt, dup_cnt;

  // Narrow-counter instance sharing all inputs, used to reach saturation quickly.
  logic        s_in_ready, s_shift_en, s_mac_en, s_mac_clr, s_mac_last, s_out_valid, s_busy;
  logic [3:0]  s_tap_idx;
  logic [31:0] s_phase;
  logic [1:0]  s_skip_cnt, s_dup_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  resample_sched #(.TAP_COUNT(TAPS), .PHASE_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step_in(step_in), .in_valid(in_valid),
    .in_ready(in_ready), .shift_en(shift_en), .tap_idx(tap_idx), .mac_en(mac_en),
    .mac_clr(mac_clr), .mac_last(mac_last), .out_valid(out_valid), .out_ready(out_ready),
    .phase(phase), .skip_cnt(skip_cnt), .dup_cnt(dup_cnt), .busy(busy)
  );

  resample_sched #(.TAP_COUNT(TAPS), .PHASE_W(32), .CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(en), .step_in(step_in), .in_valid(in_valid),
    .in_ready(s_in_ready), .shift_en(s_shift_en), .tap_idx(s_tap_idx), .mac_en(s_mac_en),
    .mac_clr(s_mac_clr), .mac_last(s_mac_last), .out_valid(s_out_valid),
    .out_ready(out_ready), .phase(s_phase), .skip_cnt(s_skip_cnt), .dup_cnt(s_dup_cnt),
    .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per completed output handshake.
  typedef struct {
    logic [31:0] phase;
    int          shifts;
    int          fetch;
    bit          mac_ok;
    int          skip;
    int          dup;
    int          period;
  } rec_t;

  rec_t recq[$];
  int   cyc = 0;
  int   m_shifts, m_fetch, m_mac, last_hs;
  bit   m_ok;

  always @(negedge clk) begin
    rec_t r;
    cyc++;
    if (!rst_n) begin
      m_shifts = 0; m_fetch = 0; m_mac = 0; m_ok = 1'b1; last_hs = cyc;
    end else begin
      if (shift_en) m_shifts++;
      if (in_ready) m_fetch++;
      if (mac_en) begin
        if (int'(tap_idx) != m_mac || mac_clr !== (m_mac == 0) || mac_last !== (m_mac == TAPS - 1))
          m_ok = 1'b0;
        m_mac++;
      end else if (mac_clr || mac_last) begin
        m_ok = 1'b0;
      end
      if (out_valid && out_ready) begin
        r.phase  = phase;
        r.shifts = m_shifts;
        r.fetch  = m_fetch;
        r.mac_ok = m_ok && (m_mac == TAPS);
        r.skip   = int'(skip_cnt);
        r.dup    = int'(dup_cnt);
        r.period = cyc - last_hs;
        recq.push_back(r);
        m_shifts = 0; m_fetch = 0; m_mac = 0; m_ok = 1'b1; last_hs = cyc;
      end
    end
  end

  // Reference model: per-output phase, inputs consumed and running counts.
  logic [31:0] e_phase[$];
  int          e_shift[$];
  int          e_skip[$];
  int          e_dup[$];

  task automatic model_run(input logic [31:0] st, input int n);
    logic [31:0] ph;
    longint      s;
    int          c, sk, dp;
    ph = 32'h0; sk = 0; dp = 0;
    e_phase.delete(); e_shift.delete(); e_skip.delete(); e_dup.delete();
    for (int i = 0; i < n; i++) begin
      s = longint'($signed(ph)) + longint'($signed(st));
      if (s > PMAX) c = 2;
      else if (s < PMIN) c = 0;
      else c = 1;
      ph = s[31:0];
      if (c == 2) sk++;
      if (c == 0) dp++;
      e_phase.push_back(ph);
      e_shift.push_back(c);
      e_skip.push_back(sk);
      e_dup.push_back(dp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b1; out_ready = 1'b1; step_in = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    recq.delete();
  endtask

  task automatic run_until(input int n, input bit rnd, input int budget);
    for (int i = 0; i < budget && recq.size() < n; i++) begin
      @(posedge clk); #1;
      if (rnd) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b1; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    en = 1'b1; step_in = 32'h1234_5678;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (phase !== 32'h0) begin n_fail++; $display("FAIL reset_phase: got %h want 0", phase); end
    n_checks++;
    if (skip_cnt !== 16'h0 || dup_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", skip_cnt, dup_cnt);
    end
    n_checks++;
    if (tap_idx !== 4'h0) begin n_fail++; $display("FAIL reset_tap: got %h want 0", tap_idx); end
    n_checks++;
    if ({in_ready, shift_en, mac_en, mac_clr, mac_last, out_valid, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {in_ready, shift_en, mac_en, mac_clr, mac_last, out_valid, busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unity();
    do_reset();
    en = 1'b1; step_in = 32'h0;
    run_until(5, 1'b0, 200);
    n_checks++;
    if (recq.size() != 5) begin n_fail++; $display("FAIL unity_count: got %0d want 5", recq.size()); end
    for (int i = 0; i < recq.size(); i++) begin
      n_checks++;
      if (recq[i].phase !== 32'h0 || recq[i].shifts != 1 || !recq[i].mac_ok ||
          recq[i].skip != 0 || recq[i].dup != 0) begin
        n_fail++;
        $display("FAIL unity_out%0d: got ph=%h sh=%0d mac=%0d sk=%0d dp=%0d want 0/1/1/0/0", i,
                 recq[i].phase, recq[i].shifts, recq[i].mac_ok, recq[i].skip, recq[i].dup);
      end
      if (i > 0) begin
        n_checks++;
        if (recq[i].period != TAPS + 2) begin
          n_fail++; $display("FAIL unity_period%0d: got %0d want %0d", i, recq[i].period, TAPS + 2);
        end
      end
    end
  endtask

  task automatic test_skip();
    do_reset();
    en = 1'b1; step_in = 32'h4000_0000;
    model_run(32'h4000_0000, 6);
    run_until(6, 1'b0, 300);
    n_checks++;
    if (recq.size() != 6) begin n_fail++; $display("FAIL skip_count: got %0d want 6", recq.size()); end
    for (int i = 0; i < recq.size(); i++) begin
      n_checks++;
      if (recq[i].phase !== e_phase[i] || recq[i].shifts != e_shift[i] ||
          recq[i].skip != e_skip[i] || recq[i].dup != e_dup[i] || !recq[i].mac_ok) begin
        n_fail++;
        $display("FAIL skip_out%0d: got ph=%h sh=%0d sk=%0d dp=%0d want ph=%h sh=%0d sk=%0d dp=%0d",
                 i, recq[i].phase, recq[i].shifts, recq[i].skip, recq[i].dup,
                 e_phase[i], e_shift[i], e_skip[i], e_dup[i]);
      end
    end
    if (recq.size() == 6) begin
      n_checks++;
      if (recq[1].phase !== 32'h8000_0000 || recq[1].shifts != 2 || recq[5].skip != 2) begin
        n_fail++;
        $display("FAIL skip_fixed: got ph=%h sh=%0d sk6=%0d want 80000000/2/2",
                 recq[1].phase, recq[1].shifts, recq[5].skip);
      end
    end
  endtask

  task automatic test_dup();
    do_reset();
    en = 1'b1; step_in = 32'hC000_0000;
    model_run(32'hC000_0000, 4);
    run_until(4, 1'b0, 200);
    n_checks++;
    if (recq.size() != 4) begin n_fail++; $display("FAIL dup_count: got %0d want 4", recq.size()); end
    for (int i = 0; i < recq.size(); i++) begin
      n_checks++;
      if (recq[i].phase !== e_phase[i] || recq[i].shifts != e_shift[i] ||
          recq[i].dup != e_dup[i] || !recq[i].mac_ok) begin
        n_fail++;
        $display("FAIL dup_out%0d: got ph=%h sh=%0d dp=%0d want ph=%h sh=%0d dp=%0d", i,
                 recq[i].phase, recq[i].shifts, recq[i].dup, e_phase[i], e_shift[i], e_dup[i]);
      end
    end
    if (recq.size() == 4) begin
      n_checks++;
      if (recq[2].fetch != 0 || recq[2].phase !== 32'h4000_0000 || recq[2].dup != 1) begin
        n_fail++;
        $display("FAIL dup_fixed: got fetch=%0d ph=%h dp=%0d want 0/40000000/1",
                 recq[2].fetch, recq[2].phase, recq[2].dup);
      end
    end
  endtask

  task automatic test_stall();
    int k;
    do_reset();
    en = 1'b1; step_in = 32'h1000_0000; in_valid = 1'b0; out_ready = 1'b0;
    for (k = 0; k < 10 && !in_ready; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_fetch_reached: got %b want 1", in_ready); end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (in_ready !== 1'b1 || shift_en !== 1'b0 || mac_en !== 1'b0 || phase !== 32'h1000_0000) begin
        n_fail++;
        $display("FAIL stall_fetch%0d: got rdy=%b sh=%b mac=%b ph=%h want 1/0/0/10000000",
                 c, in_ready, shift_en, mac_en, phase);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    for (k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_reached: got %b want 1", out_valid); end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || phase !== 32'h1000_0000 || tap_idx !== 4'h0 ||
          mac_en !== 1'b0 || in_ready !== 1'b0 || shift_en !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_out%0d: got ov=%b ph=%h tap=%h mac=%b rdy=%b want 1/10000000/0/0/0",
                 c, out_valid, phase, tap_idx, mac_en, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    run_until(2, 1'b0, 100);
    n_checks++;
    if (recq.size() != 2 || recq[0].shifts != 1 || recq[1].phase !== 32'h2000_0000) begin
      n_fail++;
      $display("FAIL stall_resume: got n=%0d want 2 outputs, 1 shift, second phase 20000000",
               recq.size());
    end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    en = 1'b1; step_in = 32'h2000_0000;
    for (k = 0; k < 40 && !(mac_en && tap_idx == 4'd4); k++) begin @(posedge clk); #1; end
    n_checks++;
    if (!(mac_en === 1'b1 && tap_idx === 4'd4)) begin
      n_fail++; $display("FAIL rmid_reach: got mac=%b tap=%h want 1/4", mac_en, tap_idx);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (phase !== 32'h0 || tap_idx !== 4'h0 || skip_cnt !== 16'h0 || dup_cnt !== 16'h0 ||
        {in_ready, shift_en, mac_en, mac_clr, mac_last, out_valid, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL rmid_state: got ph=%h tap=%h ctrl=%b want 0/0/0000000", phase, tap_idx,
               {in_ready, shift_en, mac_en, mac_clr, mac_last, out_valid, busy});
    end
    rst_n = 1'b1;
    recq.delete();
    for (k = 0; k < 50 && !out_valid; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (k != TAPS + 2) begin n_fail++; $display("FAIL rmid_latency: got %0d want %0d", k, TAPS + 2); end
    run_until(1, 1'b0, 20);
    n_checks++;
    if (recq.size() != 1 || recq[0].phase !== 32'h2000_0000 || recq[0].shifts != 1) begin
      n_fail++; $display("FAIL rmid_first: got n=%0d want one fresh output at phase 20000000", recq.size());
    end
  endtask

  task automatic test_en_drop();
    int k;
    do_reset();
    en = 1'b1; step_in = 32'h0;
    for (k = 0; k < 20 && !mac_en; k++) begin @(posedge clk); #1; end
    en = 1'b0;
    for (k = 0; k < 20 && !out_valid; k++) begin @(posedge clk); #1; end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL endrop_out: got %b want 1", out_valid); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL endrop_idle%0d: got busy=%b ov=%b rdy=%b want 0/0/0", c, busy, out_valid, in_ready);
      end
    end
    n_checks++;
    if (recq.size() != 1) begin n_fail++; $display("FAIL endrop_count: got %0d want 1", recq.size()); end
  endtask

  task automatic test_saturation();
    logic [31:0] st[2];
    st[0] = 32'h7FFF_FFFF;
    st[1] = 32'h8000_0001;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      en = 1'b1; step_in = st[t];
      model_run(st[t], 12);
      run_until(12, 1'b0, 600);
      n_checks++;
      if (int'(skip_cnt) != e_skip[11] || int'(dup_cnt) != e_dup[11]) begin
        n_fail++;
        $display("FAIL sat_wide%0d: got sk=%0d dp=%0d want sk=%0d dp=%0d", t,
                 skip_cnt, dup_cnt, e_skip[11], e_dup[11]);
      end
      n_checks++;
      if (int'(s_skip_cnt) != ((e_skip[11] > 3) ? 3 : e_skip[11]) ||
          int'(s_dup_cnt) != ((e_dup[11] > 3) ? 3 : e_dup[11])) begin
        n_fail++;
        $display("FAIL sat_narrow%0d: got sk=%0d dp=%0d want sk=%0d dp=%0d (saturated at 3)", t,
                 s_skip_cnt, s_dup_cnt, (e_skip[11] > 3) ? 3 : e_skip[11],
                 (e_dup[11] > 3) ? 3 : e_dup[11]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] st;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      st = $urandom;
      en = 1'b1; step_in = st;
      model_run(st, 15);
      run_until(15, 1'b1, 3000);
      n_checks++;
      if (recq.size() != 15) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d want 15", t, recq.size());
      end
      for (int i = 0; i < recq.size(); i++) begin
        n_checks++;
        if (recq[i].phase !== e_phase[i] || recq[i].shifts != e_shift[i] ||
            recq[i].skip != e_skip[i] || recq[i].dup != e_dup[i] || !recq[i].mac_ok) begin
          n_fail++;
          $display("FAIL rand%0d_out%0d: step=%h got ph=%h sh=%0d sk=%0d dp=%0d mac=%0d want ph=%h sh=%0d sk=%0d dp=%0d mac=1",
                   t, i, st, recq[i].phase, recq[i].shifts, recq[i].skip, recq[i].dup,
                   recq[i].mac_ok, e_phase[i], e_shift[i], e_skip[i], e_dup[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; step_in = 32'h0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_unity();
    test_skip();
    test_dup();
    test_stall();
    test_reset_mid();
    test_en_drop();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
